// File: rtl/my_package.sv
// Shared entry types and sizing constants for the front-end and back-end queues.
package my_package;

  localparam int FQ_DEPTH = 8;

  // One fetched instruction as held in the fetch queue.
  typedef struct packed {
    logic [31:0] inst;
    logic [7:0]  pc;
  } fq_entry;

  typedef struct packed {
    logic        busy;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [2:0]  rob_tag;
  } res_entry;

  typedef struct packed {
    logic        done;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [7:0]  pc;
  } rob_entry;

endpackage

// File: rtl/fetch_queue.sv
// Two-wide in, two-wide out circular instruction buffer between fetch and decode.
module fetch_queue
  import my_package::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid_1,
  input  logic [31:0]                push_inst_1,
  input  logic [7:0]                 push_pc_1,
  input  logic                       push_valid_2,
  input  logic [31:0]                push_inst_2,
  input  logic [7:0]                 push_pc_2,
  output logic                       push_ready,
  input  logic [1:0]                 pop_req,
  output logic                       pop_valid_1,
  output logic [31:0]                pop_inst_1,
  output logic [7:0]                 pop_pc_1,
  output logic                       pop_valid_2,
  output logic [31:0]                pop_inst_2,
  output logic [7:0]                 pop_pc_2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [AW-1:0] ptr_t;

  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  fq_entry       mem_q [DEPTH];
  fq_entry       mem_d [DEPTH];

  logic [1:0]    pop_eff;
  logic [1:0]    pop_n;
  logic [1:0]    push_n;
  fq_entry       head_e1, head_e2;

  // Handshake: fetch presents slot 1 (older) and optionally slot 2 (younger);
  // both are taken at the edge when push_ready=1, where push_ready promises room
  // for two based only on the registered count. Decode sees the two oldest
  // entries show-ahead and names in pop_req how many it consumes; the queue
  // never retires more than it holds.
  always_comb begin
    push_ready = (count_q <= CW'(DEPTH - 2));
    pop_eff    = (pop_req == 2'd3) ? 2'd2 : pop_req;
    pop_n      = (CW'(pop_eff) > count_q) ? count_q[1:0] : pop_eff;

    push_n = 2'd0;
    if (push_ready && push_valid_1) begin
      push_n = push_valid_2 ? 2'd2 : 2'd1;
    end

    mem_d   = mem_q;
    head_d  = head_q + ptr_t'(pop_n);
    tail_d  = tail_q + ptr_t'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);

    if (push_n != 2'd0) begin
      mem_d[tail_q] = '{inst: push_inst_1, pc: push_pc_1};
    end
    if (push_n == 2'd2) begin
      mem_d[tail_q + ptr_t'(1)] = '{inst: push_inst_2, pc: push_pc_2};
    end

    // Flush drops everything in flight, including this cycle's pushes and pops.
    if (flush) begin
      mem_d   = mem_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head_e1 = mem_q[head_q];
  assign head_e2 = mem_q[head_q + ptr_t'(1)];

  assign pop_valid_1 = (count_q >= CW'(1));
  assign pop_valid_2 = (count_q >= CW'(2));
  assign pop_inst_1  = head_e1.inst;
  assign pop_pc_1    = head_e1.pc;
  assign pop_inst_2  = head_e2.inst;
  assign pop_pc_2    = head_e2.pc;
  assign count       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference of the stored stream.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int W     = 40;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid_1;
  logic [31:0] push_inst_1;
  logic [7:0]  push_pc_1;
  logic        push_valid_2;
  logic [31:0] push_inst_2;
  logic [7:0]  push_pc_2;
  logic        push_ready;
  logic [1:0]  pop_req;
  logic        pop_valid_1;
  logic [31:0] pop_inst_1;
  logic [7:0]  pop_pc_1;
  logic        pop_valid_2;
  logic [31:0] pop_inst_2;
  logic [7:0]  pop_pc_2;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   next_pc = 8'd0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid_1(push_valid_1), .push_inst_1(push_inst_1), .push_pc_1(push_pc_1),
    .push_valid_2(push_valid_2), .push_inst_2(push_inst_2), .push_pc_2(push_pc_2),
    .push_ready(push_ready), .pop_req(pop_req),
    .pop_valid_1(pop_valid_1), .pop_inst_1(pop_inst_1), .pop_pc_1(pop_pc_1),
    .pop_valid_2(pop_valid_2), .pop_inst_2(pop_inst_2), .pop_pc_2(pop_pc_2),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] inst_of(input logic [7:0] pc);
    if (pc == 8'd0) return 32'h00500093;
    if (pc == 8'd4) return 32'h00A00113;
    return 32'h13000000 | {24'd0, pc};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls; checks show-ahead outputs before the
  // edge and occupancy after it against the reference queue.
  task automatic cycle(input logic pv1, input logic pv2, input logic [1:0] preq,
                       input logic fl, input logic rs, input string tag);
    int n;
    int take;
    logic ready_exp;
    push_valid_1 = pv1;
    push_valid_2 = pv2;
    push_pc_1    = next_pc;
    push_inst_1  = inst_of(next_pc);
    push_pc_2    = next_pc + 8'd4;
    push_inst_2  = inst_of(next_pc + 8'd4);
    pop_req      = preq;
    flush        = fl;
    rst          = rs;
    #1;
    n = exp_q.size();
    ready_exp = (n <= DEPTH - 2);
    chk({tag, ".push_ready"}, {39'd0, push_ready}, {39'd0, ready_exp});
    chk({tag, ".pop_valid_1"}, {39'd0, pop_valid_1}, {39'd0, n >= 1});
    chk({tag, ".pop_valid_2"}, {39'd0, pop_valid_2}, {39'd0, n >= 2});
    if (n >= 1) chk({tag, ".head1"}, {pop_inst_1, pop_pc_1}, exp_q[0]);
    if (n >= 2) chk({tag, ".head2"}, {pop_inst_2, pop_pc_2}, exp_q[1]);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      take = (preq == 2'd3) ? 2 : int'(preq);
      if (take > n) take = n;
      for (int i = 0; i < take; i++) void'(exp_q.pop_front());
      if (ready_exp && pv1) begin
        exp_q.push_back({inst_of(next_pc), next_pc});
        next_pc = next_pc + 8'd4;
        if (pv2) begin
          exp_q.push_back({inst_of(next_pc), next_pc});
          next_pc = next_pc + 8'd4;
        end
      end
    end
    chk({tag, ".count"}, {36'd0, count}, 40'(exp_q.size()));
    push_valid_1 = 1'b0;
    push_valid_2 = 1'b0;
    pop_req      = 2'd0;
    flush        = 1'b0;
    rst          = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; pop_req = 2'd0;
    push_valid_1 = 1'b0; push_inst_1 = '0; push_pc_1 = '0;
    push_valid_2 = 1'b0; push_inst_2 = '0; push_pc_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.count", {36'd0, count}, 40'd0);
    chk("reset.pop_valid_1", {39'd0, pop_valid_1}, 40'd0);
    chk("reset.pop_valid_2", {39'd0, pop_valid_2}, 40'd0);
    chk("reset.push_ready", {39'd0, push_ready}, 40'd1);

    // first pair, and no bypass onto the pop side in the push cycle
    push_valid_1 = 1'b1; push_valid_2 = 1'b1;
    #1;
    chk("bypass.pop_valid_1", {39'd0, pop_valid_1}, 40'd0);
    cycle(1, 1, 2'd0, 0, 0, "first_pair");
    chk("first.count", {36'd0, count}, 40'd2);
    chk("first.pop_inst_1", {8'd0, pop_inst_1}, 40'h0000500093);
    chk("first.pop_pc_2", {32'd0, pop_pc_2}, 40'd4);

    // fill to full; a further push is refused
    for (int i = 0; i < 3; i++) cycle(1, 1, 2'd0, 0, 0, "fill");
    chk("full.count", {36'd0, count}, 40'd8);
    chk("full.push_ready", {39'd0, push_ready}, 40'd0);
    cycle(1, 1, 2'd0, 0, 0, "push_when_full");
    chk("full_hold.count", {36'd0, count}, 40'd8);

    // drain two per cycle while refilling across the pointer wrap
    for (int i = 0; i < 6; i++) begin
      cycle(exp_q.size() <= DEPTH - 2, exp_q.size() <= DEPTH - 2, 2'd2, 0, 0, "wrap");
      chk("wrap.count_le_8", {39'd0, count <= 4'd8}, 40'd1);
    end

    // drain, including pop_req=3 and an over-request at count 1
    cycle(0, 0, 2'd3, 0, 0, "pop3");
    cycle(0, 0, 2'd2, 0, 0, "pop2");
    cycle(0, 0, 2'd1, 0, 0, "pop1");
    chk("one_left.count", {36'd0, count}, 40'd1);
    cycle(0, 0, 2'd2, 0, 0, "overpop");
    chk("overpop.count", {36'd0, count}, 40'd0);
    chk("overpop.pop_valid_1", {39'd0, pop_valid_1}, 40'd0);
    cycle(0, 0, 2'd2, 0, 0, "pop_empty");
    chk("empty.count", {36'd0, count}, 40'd0);

    // five entries then flush with a simultaneous push and pop
    cycle(1, 1, 2'd0, 0, 0, "refill_a");
    cycle(1, 1, 2'd0, 0, 0, "refill_b");
    cycle(1, 0, 2'd0, 0, 0, "refill_single");
    chk("five.count", {36'd0, count}, 40'd5);
    cycle(1, 1, 2'd2, 1, 0, "flush");
    chk("flush.count", {36'd0, count}, 40'd0);
    chk("flush.pop_valid_1", {39'd0, pop_valid_1}, 40'd0);
    chk("flush.push_ready", {39'd0, push_ready}, 40'd1);

    // illegal slot-2-only push, then reset in the middle of a push
    cycle(0, 1, 2'd0, 0, 0, "slot2_only");
    chk("slot2_only.count", {36'd0, count}, 40'd0);
    cycle(1, 1, 2'd0, 0, 0, "pre_rst");
    cycle(1, 1, 2'd1, 0, 1, "rst_push");
    chk("rst_push.count", {36'd0, count}, 40'd0);
    cycle(1, 1, 2'd0, 0, 0, "post_rst");
    cycle(0, 0, 2'd2, 0, 0, "post_rst_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
